// File: rtl/fullchip_seq_ctrl.sv
// Instruction sequencer for the fullchip attention core: walks the Q/K write, K load,
// execute, ofifo->pmem move, SFP and readout phases and emits a registered inst word.
module fullchip_seq_ctrl #(
   parameter int TOTAL_CYCLE = 8,
   parameter int COL         = 8,
   parameter int AW          = 4,
   parameter int GAP         = 10,
   parameter int DRAIN       = 3,
   localparam int NQW        = $clog2(TOTAL_CYCLE + 1),
   localparam int IW         = 2 * AW + 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [NQW-1:0] n_q,
   input  logic           k_reuse,
   input  logic           norm_en,
   input  logic           in_valid,
   output logic [IW-1:0]  inst,
   output logic           acc,
   output logic           div,
   output logic           fifo_ext_rd,
   output logic           data_is_k,
   output logic [AW-1:0]  data_idx,
   output logic           busy,
   output logic           done
);

   localparam int M1      = (TOTAL_CYCLE + 3 > COL + 1) ? TOTAL_CYCLE + 3 : COL + 1;
   localparam int M2      = (GAP > DRAIN) ? GAP : DRAIN;
   localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_QWR,
      S_KWR,
      S_KGAP,
      S_KLOAD,
      S_KTAIL,
      S_GAP_A,
      S_EXEC,
      S_GAP_B,
      S_MOVE,
      S_GAP_C,
      S_SFP,
      S_DRAIN,
      S_RDOUT,
      S_DONE
   } state_t;

   state_t          state;
   state_t          nxt_state;
   state_t          succ_state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   nxt_cnt;
   logic            beat_wr;
   logic            nxt_wr;
   logic            take_start;

   logic [CW-1:0]   n_r;
   logic            k_reuse_r;
   logic            norm_en_r;
   logic [CW-1:0]   n_resolved;

   logic [CW-1:0]   beat_cnt;
   logic [CW-1:0]   beat_target;
   logic [CW-1:0]   phase_len;
   logic            phase_last;

   logic [AW-1:0]   o_qk_add;
   logic [AW-1:0]   o_p_add;
   logic            o_ofifo_rd;
   logic            o_execute;
   logic            o_load;
   logic            o_qmem_rd;
   logic            o_qmem_wr;
   logic            o_kmem_rd;
   logic            o_kmem_wr;
   logic            o_pmem_rd;
   logic            o_pmem_wr;
   logic            o_acc;
   logic            o_div;
   logic            o_fifo_ext_rd;
   logic            o_data_is_k;
   logic [AW-1:0]   o_data_idx;
   logic            o_busy;
   logic            o_done;

   assign n_resolved = (n_q == '0 || int'(n_q) > TOTAL_CYCLE) ? CW'(TOTAL_CYCLE) : CW'(n_q);

   // beat_wr records whether the current write-phase cycle carries an accepted beat
   assign beat_cnt    = cnt + CW'(beat_wr);
   assign beat_target = (state == S_KWR) ? CW'(COL) : n_r;

   always_comb begin
      phase_len = CW'(1);
      case (state)
         S_KGAP:                    phase_len = CW'(2);
         S_KLOAD:                   phase_len = CW'(COL + 1);
         S_KTAIL:                   phase_len = CW'(1);
         S_GAP_A, S_GAP_B, S_GAP_C: phase_len = CW'(GAP);
         S_EXEC, S_MOVE, S_SFP:     phase_len = n_r;
         S_DRAIN:                   phase_len = CW'(DRAIN);
         S_RDOUT:                   phase_len = n_r + CW'(3);
         default:                   phase_len = CW'(1);
      endcase
   end

   assign phase_last = (cnt == phase_len - CW'(1));

   always_comb begin
      succ_state = S_IDLE;
      case (state)
         S_KGAP:  succ_state = S_KLOAD;
         S_KLOAD: succ_state = S_KTAIL;
         S_KTAIL: succ_state = S_GAP_A;
         S_GAP_A: succ_state = S_EXEC;
         S_EXEC:  succ_state = S_GAP_B;
         S_GAP_B: succ_state = S_MOVE;
         S_MOVE:  succ_state = S_GAP_C;
         S_GAP_C: succ_state = S_SFP;
         S_SFP:   succ_state = S_DRAIN;
         S_DRAIN: succ_state = S_RDOUT;
         S_RDOUT: succ_state = S_DONE;
         default: succ_state = S_IDLE;
      endcase
   end

   // in_valid sampled at an edge decides whether the following write cycle strobes
   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_wr     = 1'b0;
      take_start = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            nxt_state = S_IDLE;
            if (start) begin
               take_start = 1'b1;
               nxt_state  = S_QWR;
               nxt_cnt    = '0;
               nxt_wr     = in_valid;
            end
         end
         S_QWR, S_KWR: begin
            if (beat_cnt == beat_target) begin
               nxt_cnt = '0;
               if (state == S_KWR) begin
                  nxt_state = S_KGAP;
               end else if (k_reuse_r) begin
                  nxt_state = S_GAP_A;
               end else begin
                  nxt_state = S_KWR;
                  nxt_wr    = in_valid;
               end
            end else begin
               nxt_cnt = beat_cnt;
               nxt_wr  = in_valid;
            end
         end
         default: begin
            if (phase_last) begin
               nxt_state = succ_state;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         beat_wr   <= 1'b0;
         n_r       <= '0;
         k_reuse_r <= 1'b0;
         norm_en_r <= 1'b0;
      end else begin
         state   <= nxt_state;
         cnt     <= nxt_cnt;
         beat_wr <= nxt_wr;
         if (take_start) begin
            n_r       <= n_resolved;
            k_reuse_r <= k_reuse;
            norm_en_r <= norm_en;
         end
      end
   end

   // Outputs describe the cycle being entered, so they are decoded from the next state
   always_comb begin
      o_qk_add      = '0;
      o_p_add       = '0;
      o_ofifo_rd    = 1'b0;
      o_execute     = 1'b0;
      o_load        = 1'b0;
      o_qmem_rd     = 1'b0;
      o_qmem_wr     = 1'b0;
      o_kmem_rd     = 1'b0;
      o_kmem_wr     = 1'b0;
      o_pmem_rd     = 1'b0;
      o_pmem_wr     = 1'b0;
      o_acc         = 1'b0;
      o_div         = 1'b0;
      o_fifo_ext_rd = 1'b0;
      o_data_is_k   = 1'b0;
      o_data_idx    = '0;
      o_busy        = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      o_done        = (nxt_state == S_DONE);
      case (nxt_state)
         S_QWR: begin
            o_qmem_wr  = nxt_wr;
            o_qk_add   = AW'(nxt_cnt);
            o_data_idx = AW'(nxt_cnt);
         end
         S_KWR: begin
            o_kmem_wr   = nxt_wr;
            o_data_is_k = 1'b1;
            o_qk_add    = AW'(nxt_cnt);
            o_data_idx  = AW'(nxt_cnt);
         end
         S_KLOAD: begin
            o_load    = 1'b1;
            o_kmem_rd = (nxt_cnt != '0);
            o_qk_add  = (nxt_cnt <= CW'(1)) ? '0 : AW'(nxt_cnt - CW'(1));
         end
         S_KTAIL: begin
            o_load = 1'b1;
         end
         S_EXEC: begin
            o_execute = 1'b1;
            o_qmem_rd = 1'b1;
            o_qk_add  = AW'(nxt_cnt);
         end
         S_MOVE: begin
            o_ofifo_rd = 1'b1;
            o_pmem_wr  = 1'b1;
            o_p_add    = AW'(nxt_cnt);
         end
         S_SFP: begin
            o_acc     = 1'b1;
            o_pmem_rd = 1'b1;
            o_div     = norm_en_r;
            o_p_add   = AW'(nxt_cnt);
         end
         S_RDOUT: begin
            o_fifo_ext_rd = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inst        <= '0;
         acc         <= 1'b0;
         div         <= 1'b0;
         fifo_ext_rd <= 1'b0;
         data_is_k   <= 1'b0;
         data_idx    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         inst        <= {o_ofifo_rd, o_qk_add, o_p_add, o_execute, o_load, o_qmem_rd,
                         o_qmem_wr, o_kmem_rd, o_kmem_wr, o_pmem_rd, o_pmem_wr};
         acc         <= o_acc;
         div         <= o_div;
         fifo_ext_rd <= o_fifo_ext_rd;
         data_is_k   <= o_data_is_k;
         data_idx    <= o_data_idx;
         busy        <= o_busy;
         done        <= o_done;
      end
   end

endmodule

// File: tb/tb_fullchip_seq_ctrl.sv
// Self-checking bench for fullchip_seq_ctrl: per-cycle trace expanded from the phase list,
// compared through a scoreboard queue, plus busy-length checks from a vector table.
module tb_fullchip_seq_ctrl;

   localparam int TC    = 8;
   localparam int COL   = 8;
   localparam int AW    = 4;
   localparam int GAP   = 10;
   localparam int DRAIN = 3;

   typedef struct {
      bit          iv;
      logic [27:0] outs;
   } exp_t;

   typedef struct {
      int n_q;
      bit k_reuse;
      bit norm_en;
      int stall_a;
      int stall_b;
      bit mid_start;
      int abort_at;
      int exp_busy;
      int id;
   } run_vec_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  n_q;
   logic        k_reuse;
   logic        norm_en;
   logic        in_valid;
   logic [16:0] inst;
   logic        acc;
   logic        div;
   logic        fifo_ext_rd;
   logic        data_is_k;
   logic [3:0]  data_idx;
   logic        busy;
   logic        done;

   exp_t     plan[$];
   exp_t     sb[$];
   run_vec_t vecs[8];
   int       tests = 0;
   int       failures = 0;

   fullchip_seq_ctrl #(
      .TOTAL_CYCLE(TC), .COL(COL), .AW(AW), .GAP(GAP), .DRAIN(DRAIN)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .n_q(n_q), .k_reuse(k_reuse),
      .norm_en(norm_en), .in_valid(in_valid), .inst(inst), .acc(acc), .div(div),
      .fifo_ext_rd(fifo_ext_rd), .data_is_k(data_is_k), .data_idx(data_idx),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t cyc(input bit iv, input bit ofifo, input int qa, input int pa,
                                input bit ex, input bit ld, input bit qrd, input bit qwr,
                                input bit krd, input bit kwr, input bit prd, input bit pwr,
                                input bit ac, input bit dv, input bit fr, input bit dk,
                                input int di, input bit bsy, input bit dn);
      exp_t        e;
      logic [16:0] ins;
      ins    = {ofifo, 4'(qa), 4'(pa), ex, ld, qrd, qwr, krd, kwr, prd, pwr};
      e.iv   = iv;
      e.outs = {ins, ac, dv, fr, dk, 4'(di), bsy, dn};
      return e;
   endfunction

   function automatic exp_t quiet(input bit bsy);
      return cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bsy, 0);
   endfunction

   // Expected cycle-by-cycle trace of one run, straight from the phase list
   task automatic build_plan(input run_vec_t v);
      int n;
      n = (v.n_q == 0 || v.n_q > TC) ? TC : v.n_q;
      plan.delete();
      for (int b = 0; b < n; b++) begin
         if (b == v.stall_a || b == v.stall_b)
            plan.push_back(cyc(0, 0, b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, b, 1, 0));
         plan.push_back(cyc(1, 0, b, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, b, 1, 0));
      end
      if (!v.k_reuse) begin
         for (int b = 0; b < COL; b++)
            plan.push_back(cyc(1, 0, b, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, b, 1, 0));
         for (int i = 0; i < 2; i++) plan.push_back(quiet(1));
         for (int k = 0; k <= COL; k++)
            plan.push_back(cyc(1, 0, (k <= 1) ? 0 : k - 1, 0, 0, 1, 0, 0, (k >= 1), 0, 0, 0,
                               0, 0, 0, 0, 0, 1, 0));
         plan.push_back(cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      for (int i = 0; i < GAP; i++) plan.push_back(quiet(1));
      for (int i = 0; i < n; i++)
         plan.push_back(cyc(1, 0, i, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < GAP; i++) plan.push_back(quiet(1));
      for (int i = 0; i < n; i++)
         plan.push_back(cyc(1, 1, 0, i, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
      for (int i = 0; i < GAP; i++) plan.push_back(quiet(1));
      for (int i = 0; i < n; i++)
         plan.push_back(cyc(1, 0, 0, i, 0, 0, 0, 0, 0, 0, 1, 0, 1, v.norm_en, 0, 0, 0, 1, 0));
      for (int i = 0; i < DRAIN; i++) plan.push_back(quiet(1));
      for (int i = 0; i < n + 3; i++)
         plan.push_back(cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      plan.push_back(cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      plan.push_back(quiet(0));
   endtask

   task automatic checkOutput(input int vid, input int cyc_idx);
      exp_t        e;
      logic [27:0] act;
      act = {inst, acc, div, fifo_ext_rd, data_is_k, data_idx, busy, done};
      tests++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL sb_empty vec %0d cycle %0d: got %h, nothing expected", vid, cyc_idx, act);
         return;
      end
      e = sb.pop_front();
      if (act !== e.outs) begin
         failures++;
         $display("[TB] FAIL outputs vec %0d cycle %0d: got %h expected %h", vid, cyc_idx, act, e.outs);
      end
   endtask

   task automatic applyStimulus(input run_vec_t v);
      int busy_cnt;
      busy_cnt = 0;
      build_plan(v);
      n_q      = 4'(v.n_q);
      k_reuse  = v.k_reuse;
      norm_en  = v.norm_en;
      start    = 1'b1;
      sb.push_back(plan[0]);
      in_valid = plan[0].iv;
      for (int k = 0; k < plan.size(); k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_cnt++;
         checkOutput(v.id, k);
         if (k == v.abort_at) begin
            reset = 1'b1;
            sb.push_back(quiet(0));
            @(negedge clk);
            reset = 1'b0;
            checkOutput(v.id, k + 1);
            sb.push_back(quiet(0));
            @(negedge clk);
            checkOutput(v.id, k + 2);
            return;
         end
         if (v.mid_start && k == 20) begin
            start = 1'b1;
            n_q   = 4'd3;
         end
         if (k + 1 < plan.size()) begin
            sb.push_back(plan[k + 1]);
            in_valid = plan[k + 1].iv;
         end else begin
            in_valid = 1'b1;
         end
      end
      tests++;
      if (busy_cnt != v.exp_busy) begin
         failures++;
         $display("[TB] FAIL busy_len vec %0d: got %0d cycles expected %0d", v.id, busy_cnt, v.exp_busy);
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      n_q      = 4'd0;
      k_reuse  = 1'b0;
      norm_en  = 1'b0;
      in_valid = 1'b1;

      //          n_q kr ne  sa  sb mid abort busy id
      vecs[0] = '{8,  0, 0, -1, -1, 0,  -1,  96,  0};
      vecs[1] = '{8,  1, 0, -1, -1, 0,  -1,  76,  1};
      vecs[2] = '{3,  0, 0, -1, -1, 0,  -1,  71,  2};
      vecs[3] = '{8,  0, 0,  2,  5, 0,  -1,  98,  3};
      vecs[4] = '{8,  0, 0, -1, -1, 0,  39,  0,   4};
      vecs[5] = '{8,  0, 0, -1, -1, 0,  -1,  96,  5};
      vecs[6] = '{0,  0, 1, -1, -1, 1,  -1,  96,  6};
      vecs[7] = '{12, 1, 1, -1, -1, 0,  -1,  76,  7};

      repeat (3) @(negedge clk);
      sb.push_back(quiet(0));
      checkOutput(-1, 0);
      reset = 1'b0;
      @(negedge clk);
      sb.push_back(quiet(0));
      checkOutput(-1, 1);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
